// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flash_arbiter
//  Description : Two-requester round-robin arbiter in front of a single flash
//                read engine. A granted read either completes when the engine
//                pulses mem_ready, or is aborted after TIMEOUT busy cycles.
//                Each transaction is followed by one GAP cycle with mem_en low
//                so that the engine can reset before the next grant.
//  Ports       : clk, reset (async, active-high)
//                r0_req/r0_addr -> r0_ack/r0_data/r0_err   requester 0
//                r1_req/r1_addr -> r1_ack/r1_data/r1_err   requester 1
//                mem_en/mem_addr -> engine, mem_ready/mem_data <- engine
//                busy  : arbiter is not idle
//                grant : requester currently or last served
//  Revision    : 1.0  initial release
// ============================================================================
module flash_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req,
    input  logic [23:0] r0_addr,
    output logic        r0_ack,
    output logic [15:0] r0_data,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic [23:0] r1_addr,
    output logic        r1_ack,
    output logic [15:0] r1_data,
    output logic        r1_err,
    output logic        mem_en,
    output logic [23:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic        busy,
    output logic        grant
);

    localparam int                    c_timer_w    = $clog2(TIMEOUT) + 1;
    localparam logic [c_timer_w-1:0]  c_timer_last = c_timer_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_gap  = 2'd2;

    logic [1:0]           r_state;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_grant;
    logic                 r_mem_en;
    logic [23:0]          r_mem_addr;
    logic                 r_ack0, r_ack1;
    logic [15:0]          r_data0, r_data1;
    logic                 r_err0, r_err1;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic [c_timer_w-1:0] w_timer_nxt;
    logic                 w_grant_nxt;
    logic                 w_mem_en_nxt;
    logic [23:0]          w_mem_addr_nxt;
    logic                 w_ack0_nxt, w_ack1_nxt;
    logic [15:0]          w_data0_nxt, w_data1_nxt;
    logic                 w_err0_nxt, w_err1_nxt;

    logic                 w_any_req;
    logic                 w_pick;
    logic                 w_done;
    logic [15:0]          w_result;

    assign w_any_req = r0_req | r1_req;
    // On a tie the side that was not served last wins; otherwise the lone requester.
    assign w_pick    = (r0_req & r1_req) ? ~r_grant : r1_req;
    // mem_ready has priority over the timeout when both land in the same cycle.
    assign w_done    = mem_ready | (r_timer == c_timer_last);
    assign w_result  = mem_ready ? mem_data : 16'h0000;

    // ------------------------------------------------------------------
    // State register (also registers every output)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_timer    <= '0;
            r_grant    <= 1'b1;
            r_mem_en   <= 1'b0;
            r_mem_addr <= 24'h000000;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_data0    <= 16'h0000;
            r_data1    <= 16'h0000;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_grant    <= w_grant_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_data0    <= w_data0_nxt;
            r_data1    <= w_data1_nxt;
            r_err0     <= w_err0_nxt;
            r_err1     <= w_err1_nxt;
            r_busy     <= (w_state_nxt != c_st_idle);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any_req) w_state_nxt = c_st_busy;
            c_st_busy: if (w_done)    w_state_nxt = c_st_gap;
            c_st_gap:                 w_state_nxt = c_st_idle;
            default:                  w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_timer_nxt    = r_timer;
        w_grant_nxt    = r_grant;
        w_mem_en_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_ack0_nxt     = 1'b0;
        w_ack1_nxt     = 1'b0;
        w_data0_nxt    = r_data0;
        w_data1_nxt    = r_data1;
        w_err0_nxt     = r_err0;
        w_err1_nxt     = r_err1;
        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_grant_nxt    = w_pick;
                    w_mem_addr_nxt = w_pick ? r1_addr : r0_addr;
                    w_mem_en_nxt   = 1'b1;
                    w_timer_nxt    = '0;
                end
            end
            c_st_busy: begin
                if (w_done) begin
                    // Only the granted side's result registers move.
                    if (r_grant) begin
                        w_ack1_nxt  = 1'b1;
                        w_data1_nxt = w_result;
                        w_err1_nxt  = ~mem_ready;
                    end else begin
                        w_ack0_nxt  = 1'b1;
                        w_data0_nxt = w_result;
                        w_err0_nxt  = ~mem_ready;
                    end
                end else begin
                    w_mem_en_nxt = 1'b1;
                    w_timer_nxt  = r_timer + 1'b1;
                end
            end
            default: begin
                // GAP: mem_en stays low for one cycle
            end
        endcase
    end

    assign r0_ack   = r_ack0;
    assign r0_data  = r_data0;
    assign r0_err   = r_err0;
    assign r1_ack   = r_ack1;
    assign r1_data  = r_data1;
    assign r1_err   = r_err1;
    assign mem_en   = r_mem_en;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign grant    = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_arbiter
//  Description : Self-checking bench for flash_arbiter. A transaction-level
//                reference model predicts every output each cycle; directed
//                scenarios pin the model with literal expectations, then a
//                randomized phase exercises arbitration, timeouts, spurious
//                engine pulses and asynchronous resets.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flash_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [23:0] r0_addr = 24'h0, r1_addr = 24'h0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        r0_ack, r0_err, r1_ack, r1_err, mem_en, busy, grant;
    logic [15:0] r0_data, r1_data;
    logic [23:0] mem_addr;

    // Second instance at the default TIMEOUT for the long-latency read.
    logic        b_req = 1'b0, b_ready = 1'b0;
    logic [23:0] b_addr = 24'h0;
    logic [15:0] b_data = 16'h0;
    logic        b_r0_ack, b_r0_err, b_r1_ack, b_r1_err, b_mem_en, b_busy, b_grant;
    logic [15:0] b_r0_data, b_r1_data;
    logic [23:0] b_mem_addr;

    always #5 clk = ~clk;

    flash_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_ack(r0_ack), .r0_data(r0_data), .r0_err(r0_err),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_ack(r1_ack), .r1_data(r1_data), .r1_err(r1_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .busy(busy), .grant(grant)
    );

    flash_arbiter dut_big (
        .clk(clk), .reset(reset),
        .r0_req(b_req), .r0_addr(b_addr), .r0_ack(b_r0_ack), .r0_data(b_r0_data), .r0_err(b_r0_err),
        .r1_req(1'b0), .r1_addr(24'h0), .r1_ack(b_r1_ack), .r1_data(b_r1_data), .r1_err(b_r1_err),
        .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_ready(b_ready), .mem_data(b_data),
        .busy(b_busy), .grant(b_grant)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (transaction level) ----------------
    bit          m_txn;      // a read is outstanding at the engine
    bit          m_gap;      // the single cool-down cycle after a result
    logic        m_last;     // requester served most recently
    int          m_cnt;      // busy cycles already spent without a result
    logic [23:0] m_addr;
    logic        m_ack [2];
    logic [15:0] m_data[2];
    logic        m_err [2];

    task automatic model_reset();
        m_txn = 0; m_gap = 0; m_last = 1'b1; m_cnt = 0; m_addr = 24'h0;
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 1'b0; m_data[i] = 16'h0; m_err[i] = 1'b0;
        end
    endtask

    task automatic model_result(input logic [15:0] d, input logic e);
        m_data[m_last] = d; m_err[m_last] = e; m_ack[m_last] = 1'b1;
        m_txn = 0; m_gap = 1;
    endtask

    // Applies one clock edge using the inputs currently driven.
    task automatic model_step();
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        m_ack[0] = 1'b0; m_ack[1] = 1'b0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_txn) begin
            if (mem_ready)             model_result(mem_data, 1'b0);
            else if (m_cnt + 1 == TO)  model_result(16'h0000, 1'b1);
            else                       m_cnt++;
        end else if (r0_req || r1_req) begin
            if (r0_req && r1_req) w = (m_last == 1'b1) ? 0 : 1;
            else                  w = r1_req ? 1 : 0;
            m_last = w[0];
            m_addr = (w == 1) ? r1_addr : r0_addr;
            m_txn  = 1;
            m_cnt  = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_en",   32'(mem_en),   32'(m_txn));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("busy",     32'(busy),     32'(m_txn | m_gap));
        chk("grant",    32'(grant),    32'(m_last));
        chk("r0_ack",   32'(r0_ack),   32'(m_ack[0]));
        chk("r0_data",  32'(r0_data),  32'(m_data[0]));
        chk("r0_err",   32'(r0_err),   32'(m_err[0]));
        chk("r1_ack",   32'(r1_ack),   32'(m_ack[1]));
        chk("r1_data",  32'(r1_data),  32'(m_data[1]));
        chk("r1_err",   32'(r1_err),   32'(m_err[1]));
        chk("ack_excl", 32'(r0_ack & r1_ack), 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic serve(input int lat, input logic [15:0] d);
        repeat (lat) tick();
        mem_ready = 1'b1; mem_data = d;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic exp_seq [4];
        logic        rq[2];
        logic [23:0] ra[2];
        int cnt;
        bit ok;

        exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
        model_reset();
        @(negedge clk);
        compare_all();
        chk("rst_grant",  32'(grant), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);
        chk("rst_acks",   32'({r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
        chk("rst_data",   {r0_data, r1_data}, 32'd0);
        reset = 1'b0;

        // Long-latency read on the default-TIMEOUT instance.
        b_req = 1'b1; b_addr = 24'h100000;
        tick();
        chk("big_en",    32'(b_mem_en), 32'd1);
        chk("big_grant", 32'(b_grant), 32'd0);
        ok = 1;
        repeat (40) begin
            tick();
            if (b_mem_addr !== 24'h100000 || b_mem_en !== 1'b1 || b_r0_ack !== 1'b0) ok = 0;
        end
        chk("big_hold", 32'(ok), 32'd1);
        b_ready = 1'b1; b_data = 16'hBEEF;
        tick();
        b_ready = 1'b0; b_req = 1'b0;
        chk("big_ack",  32'(b_r0_ack), 32'd1);
        chk("big_data", 32'(b_r0_data), 32'h0000BEEF);
        chk("big_err",  32'(b_r0_err), 32'd0);
        chk("big_en_off", 32'(b_mem_en), 32'd0);
        tick();
        chk("big_ack_pulse", 32'(b_r0_ack), 32'd0);
        chk("big_data_hold", 32'(b_r0_data), 32'h0000BEEF);

        // Round-robin with both requesters held continuously.
        r0_addr = 24'hA0A0A0; r1_addr = 24'h0B0B0B;
        r0_req = 1'b1; r1_req = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 32'(grant), 32'(exp_seq[k]));
            chk("rr_addr",  32'(mem_addr), exp_seq[k] ? 32'h0B0B0B : 32'hA0A0A0);
            serve(3, 16'h1000 + 16'(k));
            chk("rr_ack",  32'({r1_ack, r0_ack}), exp_seq[k] ? 32'd2 : 32'd1);
            chk("rr_data", 32'(exp_seq[k] ? r1_data : r0_data), 32'h1000 + 32'(k));
            if (k < 3) begin
                cnt = 0;
                while (mem_en !== 1'b1 && cnt < 10) begin
                    cnt++;
                    tick();
                end
                chk("rr_gap_len", 32'(cnt), 32'd2);
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        tick(); tick();

        // Timeout on requester 1.
        r1_req = 1'b1;
        tick();
        cnt = 0;
        while (mem_en === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_busy_cycles", 32'(cnt), 32'd16);
        chk("to_ack",  32'(r1_ack), 32'd1);
        chk("to_err",  32'(r1_err), 32'd1);
        chk("to_data", 32'(r1_data), 32'd0);
        r1_req = 1'b0;
        tick(); tick();
        chk("to_idle", 32'(busy), 32'd0);

        // mem_ready on the last allowed busy cycle wins over the timeout.
        r0_req = 1'b1;
        tick();
        serve(TO - 1, 16'h5A5A);
        chk("edge_ack",  32'(r0_ack), 32'd1);
        chk("edge_err",  32'(r0_err), 32'd0);
        chk("edge_data", 32'(r0_data), 32'h5A5A);
        r0_req = 1'b0;
        tick(); tick();

        // Reset five cycles into a read.
        r1_req = 1'b1; r1_addr = 24'h333333;
        tick();
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_en",   32'(mem_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd1);
        model_reset();
        compare_all();
        tick();
        reset = 1'b0;
        r0_req = 1'b1; r0_addr = 24'h444444;
        tick();
        chk("post_rst_grant", 32'(grant), 32'd0);
        chk("post_rst_addr",  32'(mem_addr), 32'h444444);
        serve(2, 16'h1234);
        r0_req = 1'b0;
        tick();
        serve(1, 16'h4321);
        r1_req = 1'b0;
        tick(); tick();

        // Address changes while busy and stray engine pulses.
        mem_ready = 1'b1; mem_data = 16'hDEAD;
        tick();
        mem_ready = 1'b0;
        chk("stray_idle", 32'({r0_ack, r1_ack}), 32'd0);
        r1_req = 1'b1; r1_addr = 24'h123456;
        tick();
        r1_addr = 24'hFFFFFF;
        tick(); tick();
        chk("addr_held", 32'(mem_addr), 32'h123456);
        serve(0, 16'h7777);
        mem_ready = 1'b1; mem_data = 16'hBAD0;
        r1_req = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk("stray_gap", 32'({r0_ack, r1_ack}), 32'd0);
        chk("stray_data", 32'(r1_data), 32'h7777);
        tick();

        // Randomized phase.
        rq[0] = 1'b0; rq[1] = 1'b0; ra[0] = 24'h0; ra[1] = 24'h0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rq[i]) begin
                    if (m_ack[i] && $urandom_range(1, 0) == 0) rq[i] = 1'b0;
                    else if ($urandom_range(7, 0) == 0)        ra[i] = 24'($urandom());
                end else if ($urandom_range(3, 0) == 0) begin
                    rq[i] = 1'b1;
                    ra[i] = 24'($urandom());
                end
            end
            r0_req = rq[0]; r0_addr = ra[0];
            r1_req = rq[1]; r1_addr = ra[1];
            mem_ready = ($urandom_range(9, 0) == 0);
            mem_data  = 16'($urandom());
            if ($urandom_range(399, 0) == 0) assert_reset();
            tick();
        end

        chk("big_r1_quiet", {b_r1_data, 13'd0, b_r1_ack, b_r1_err, b_busy}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles a granted read may wait for mem_ready before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 r0_req  input  1  requester 0 read request, level, held until r0_ack.
REQ-005 r0_addr  input  24  requester 0 flash byte address, stable while r0_req high.
REQ-006 r0_ack  output  1  one-cycle pulse: r0_data/r0_err valid.
REQ-007 r0_data  output  16  read word for requester 0, held until next r0_ack.
REQ-008 r0_err  output  1  timeout flag accompanying r0_ack.
REQ-009 r1_req, r1_addr, r1_ack, r1_data, r1_err  same directions and widths as r0_*, for requester 1.
REQ-010 mem_en  output  1  enable to flash read engine; engine idles/resets while low.
REQ-011 mem_addr  output  24  address presented to engine, stable while mem_en high.
REQ-012 mem_ready  input  1  one-cycle pulse from engine: mem_data valid.
REQ-013 mem_data  input  16  big-endian word from engine.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 grant  output  1  index of requester currently or last served.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, GAP; all outputs registered.
REQ-017 IDLE: no req -> stay IDLE, mem_en 0.
REQ-018 IDLE: exactly one req high -> grant it; latch its addr into mem_addr, mem_en<=1, timer<=0, state BUSY.
REQ-019 IDLE: both req high -> grant requester != last grant (round-robin); grant reset value 1 so requester 0 wins first tie.
REQ-020 Latency: req sampled high in IDLE at cycle N -> mem_en high and mem_addr valid from cycle N+1.
REQ-021 BUSY: mem_addr and grant SHALL not change; requester addr changes while BUSY ignored.
REQ-022 BUSY, mem_ready high at cycle M -> at M+1: granted rX_data<=mem_data, rX_err<=0, rX_ack=1, mem_en=0, state GAP.
REQ-023 BUSY, no mem_ready and timer==TIMEOUT-1 -> next cycle: rX_data<=0, rX_err<=1, rX_ack=1, mem_en=0, state GAP.
REQ-024 Timer SHALL increment each BUSY cycle, width ceil(log2(TIMEOUT))+1, no wrap before abort.
REQ-025 mem_ready and timeout in same cycle -> mem_ready wins (data, err=0).
REQ-026 mem_ready while not BUSY SHALL be ignored.
REQ-027 GAP: exactly one cycle, mem_en 0 (lets engine reset), then IDLE; earliest next mem_en rise is M+3.
REQ-028 Ungranted requester's ack/data/err SHALL not change during another's transaction.
REQ-029 Requester keeping req high after its ack SHALL be re-arbitrated in IDLE like a new request (round-robin gives other side priority on tie).
REQ-030 ack SHALL never assert on both requesters in the same cycle; at most one ack per grant.

Reset
REQ-031 reset high SHALL immediately force: state IDLE, mem_en 0, mem_addr 0, r0/r1_ack 0, r0/r1_err 0, r0/r1_data 0, busy 0, grant 1, timer 0.
REQ-032 reset mid-BUSY SHALL abort silently: no ack issued, mem_en low asynchronously.
REQ-033 After reset release, first arbitration at first clk edge with reset low.

Verification
REQ-034 r0_req=1, r0_addr=0x100000; engine mem_ready 40 cycles after mem_en with data 0xBEEF -> r0_ack one cycle, r0_data=0xBEEF, r0_err=0, mem_addr=0x100000 throughout.
REQ-035 r0_req and r1_req rise same cycle after reset, held continuously -> serve order 0,1,0,1; ack alternates; mem_en low exactly one GAP cycle plus one IDLE cycle between grants.
REQ-036 TIMEOUT=16, r1_req=1, mem_ready never asserted -> r1_ack after 16 BUSY cycles, r1_err=1, r1_data=0x0000, then IDLE.
REQ-037 mem_ready coincides with timer==TIMEOUT-1 -> ack with err=0 and engine data.
REQ-038 reset asserted 5 cycles into BUSY -> mem_en, busy, acks 0 same cycle; no ack after release; next req served by requester 0 on tie.
REQ-039 r1_addr changed mid-BUSY for r1 and spurious mem_ready pulses in IDLE/GAP -> mem_addr unchanged, no extra acks.
